wb_host_master: RTL

- Wishbone bus master sitting directly upstream of the wishbone interconnect. It drives the interconnect's m_* slave port.
- Converts host-side commands (read/write, start address, word count) into a burst of single Wishbone classic transfers.
- Streams write data in and read data out through valid/ready handshakes.
- Forwards the interconnect's aggregated interrupt to the host as a level and a one-cycle edge pulse.

---
 rtl/wb_master_pkg.sv | 17 +
 rtl/wb_master_timeout.sv | 28 ++
 rtl/wb_host_master.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone host master.
package wb_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_FETCH,
        ST_BUS,
        ST_RD_PUSH,
        ST_FIN
    } wb_state_e;

    localparam logic [3:0]  WB_SEL_ALL  = 4'hF;
    localparam int unsigned SLV_SEL_MSB = 31;
    localparam int unsigned SLV_SEL_LSB = 24;
    localparam int unsigned OFFSET_W    = 24;

endpackage

// File: rtl/wb_master_timeout.sv
// Ack-wait watchdog: cleared on load, counts enabled cycles, flags the last allowed one.
module wb_master_timeout #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(LIMIT) + 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = en && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/wb_host_master.sv
// Host-command to Wishbone classic burst master with interrupt forwarding.
// Optional ack timeout abort enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_host_master
    import wb_master_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned LEN_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              done_err,
    output logic              irq_o,
    output logic              irq_pulse,
    output logic              m_we_o,
    output logic              m_cyc_o,
    output logic              m_stb_o,
    output logic [3:0]        m_sel_o,
    output logic [ADDR_W-1:0] m_adr_o,
    output logic [DATA_W-1:0] m_dat_o,
    input  logic [DATA_W-1:0] m_dat_i,
    input  logic              m_ack_i,
    input  logic              m_int_i
);

    localparam int unsigned REM_W = LEN_W + 1;

    wb_state_e         state, state_n;
    logic [REM_W-1:0]  rem, rem_n;
    logic              is_wr, is_wr_n;
    logic [ADDR_W-1:0] adr_n;
    logic [DATA_W-1:0] dat_n, rd_data_n;
    logic              we_n, cyc_n, stb_n, rd_valid_n, done_n, err_n;

`ifdef WB_MASTER_TIMEOUT_EN
    logic tmo_load, tmo_en, tmo_expire;

    assign tmo_load = (state_n == ST_BUS) && (state != ST_BUS);
    assign tmo_en   = (state == ST_BUS) && !m_ack_i;

    wb_master_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (tmo_load),
        .en     (tmo_en),
        .expire (tmo_expire)
    );
`endif

    // rem counts words still to transfer, including the one on the bus
    always_comb begin
        state_n    = state;
        rem_n      = rem;
        is_wr_n    = is_wr;
        adr_n      = m_adr_o;
        dat_n      = m_dat_o;
        rd_data_n  = rd_data;
        we_n       = m_we_o;
        cyc_n      = m_cyc_o;
        stb_n      = m_stb_o;
        rd_valid_n = rd_valid;
        done_n     = 1'b0;
        err_n      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    adr_n   = cmd_addr;
                    rem_n   = {1'b0, cmd_len} + REM_W'(1);
                    is_wr_n = cmd_write;
                    if (cmd_write) begin
                        state_n = ST_WR_FETCH;
                    end else begin
                        state_n = ST_BUS;
                        cyc_n   = 1'b1;
                        stb_n   = 1'b1;
                        we_n    = 1'b0;
                    end
                end
            end
            ST_WR_FETCH: begin
                if (wr_valid && wr_ready) begin
                    dat_n   = wr_data;
                    we_n    = 1'b1;
                    stb_n   = 1'b1;
                    cyc_n   = 1'b1;
                    state_n = ST_BUS;
                end
            end
            ST_BUS: begin
                if (m_ack_i) begin
                    stb_n = 1'b0;
                    adr_n = {m_adr_o[SLV_SEL_MSB:SLV_SEL_LSB],
                             m_adr_o[OFFSET_W-1:0] + OFFSET_W'(1)};
                    rem_n = rem - REM_W'(1);
                    if (!is_wr) begin
                        rd_data_n  = m_dat_i;
                        rd_valid_n = 1'b1;
                        state_n    = ST_RD_PUSH;
                    end else if (rem != REM_W'(1)) begin
                        state_n = ST_WR_FETCH;
                    end else begin
                        cyc_n   = 1'b0;
                        we_n    = 1'b0;
                        done_n  = 1'b1;
                        state_n = ST_FIN;
                    end
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (tmo_expire) begin
                    stb_n   = 1'b0;
                    cyc_n   = 1'b0;
                    we_n    = 1'b0;
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                    state_n = ST_FIN;
                end
`endif
            end
            ST_RD_PUSH: begin
                if (rd_valid && rd_ready) begin
                    rd_valid_n = 1'b0;
                    if (rem != '0) begin
                        stb_n   = 1'b1;
                        state_n = ST_BUS;
                    end else begin
                        cyc_n   = 1'b0;
                        done_n  = 1'b1;
                        state_n = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                cyc_n   = 1'b0;
                stb_n   = 1'b0;
                we_n    = 1'b0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rem       <= '0;
            is_wr     <= 1'b0;
            cmd_ready <= 1'b0;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            done      <= 1'b0;
            m_we_o    <= 1'b0;
            m_cyc_o   <= 1'b0;
            m_stb_o   <= 1'b0;
            m_sel_o   <= '0;
            m_adr_o   <= '0;
            m_dat_o   <= '0;
            irq_o     <= 1'b0;
            irq_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            rem       <= rem_n;
            is_wr     <= is_wr_n;
            cmd_ready <= (state_n == ST_IDLE);
            wr_ready  <= (state_n == ST_WR_FETCH);
            rd_valid  <= rd_valid_n;
            rd_data   <= rd_data_n;
            done      <= done_n;
            m_we_o    <= we_n;
            m_cyc_o   <= cyc_n;
            m_stb_o   <= stb_n;
            m_sel_o   <= stb_n ? WB_SEL_ALL : '0;
            m_adr_o   <= adr_n;
            m_dat_o   <= dat_n;
            irq_o     <= m_int_i;
            irq_pulse <= m_int_i & ~irq_o;
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            done_err <= 1'b0;
        end else begin
            done_err <= err_n;
        end
    end
`else
    assign done_err = 1'b0;
    logic unused_err;
    assign unused_err = err_n;
`endif

endmodule
